// File: rtl/fir_result_fifo.sv
// -----------------------------------------------------------------------------
// fir_result_fifo
//
// Purpose:
//   Takes signed 16-bit FIR filter output samples and rounds each one down to
//   8 bits: divide by 2^SHIFT, rounding half toward +inf. The result is
//   registered and then queued in a small show-ahead FIFO for a
//   ready/valid consumer.
//   If a sample reaches a full FIFO and nothing is popped in that cycle, the
//   sample is dropped and the sticky Overflow flag is set.
//
// Parameters:
//   DEPTH  - number of FIFO entries; must be a power of two in 2..64
//   SHIFT  - right shift applied to the filter output, 1..8
//
// Build option:
//   FIR_RESULT_SAT_EN - when defined, a scaled value outside -128..127 is
//                       clamped. When not defined, the low 8 bits of the
//                       scaled value are kept (two's-complement wrap).
//
// Ports:
//   clk        in   single clock; all state changes on the rising edge
//   Rst        in   synchronous, active-high reset
//   Yn         in   [15:0] signed filter output sample
//   YnValid    in   Yn qualifier; one sample is accepted per cycle
//   Dout       out  [7:0] signed scaled sample at the FIFO head (show-ahead)
//   DoutValid  out  FIFO holds at least one entry
//   DoutReady  in   consumer accepts the head entry
//   Count      out  [clog2(DEPTH):0] FIFO occupancy, 0..DEPTH
//   Overflow   out  sticky flag; a sample was dropped
// -----------------------------------------------------------------------------
module fir_result_fifo #(
  parameter int DEPTH = 8,
  parameter int SHIFT = 8
) (
  input  logic                     clk,
  input  logic                     Rst,
  input  logic [15:0]              Yn,
  input  logic                     YnValid,
  output logic [7:0]               Dout,
  output logic                     DoutValid,
  input  logic                     DoutReady,
  output logic [$clog2(DEPTH):0]   Count,
  output logic                     Overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [16:0]   ROUND_INC = 17'(1 << (SHIFT - 1));

  // ---------------------------------------------------------------------------
  // Scaling: sign-extend to 17 bits, add half an LSB of the result, then shift
  // arithmetically. The 17th bit keeps 16'h7FFF + 2^(SHIFT-1) from wrapping.
  // ---------------------------------------------------------------------------
  logic signed [16:0] yn_ext;
  logic signed [16:0] yn_rnd;
  logic [7:0]         scaled;

  assign yn_ext = {Yn[15], Yn};
  assign yn_rnd = yn_ext + ROUND_INC;

`ifdef FIR_RESULT_SAT_EN
  logic signed [16:0] yn_shf;

  assign yn_shf = yn_rnd >>> SHIFT;

  always_comb begin
    scaled = yn_shf[7:0];
    if (yn_shf > 17'sd127) begin
      scaled = 8'h7F;
    end else if (yn_shf < -17'sd128) begin
      scaled = 8'h80;
    end
  end
`else
  assign scaled = 8'(yn_rnd >>> SHIFT);
`endif

  // ---------------------------------------------------------------------------
  // Stage 1 register
  // ---------------------------------------------------------------------------
  logic       s1_valid;
  logic [7:0] s1_data;

  always_ff @(posedge clk) begin
    if (Rst) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= YnValid;
    end
  end

  // The data register has no reset. The valid bit alone decides whether its
  // contents are used.
  always_ff @(posedge clk) begin
    if (YnValid) begin
      s1_data <= scaled;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO control
  // ---------------------------------------------------------------------------
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;

  assign full = (Count == FULL_CNT);
  assign pop  = DoutValid & DoutReady;
  // When the FIFO is full, a pop in the same cycle frees the slot that the
  // write pointer is already pointing at. The push can therefore still go
  // ahead.
  assign push = s1_valid & (~full | pop);
  assign drop = s1_valid & full & ~pop;

  always_ff @(posedge clk) begin
    if (Rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      Count    <= '0;
      Overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   Count <= Count + 1'b1;
        2'b01:   Count <= Count - 1'b1;
        default: Count <= Count;
      endcase
      if (drop) begin
        Overflow <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Storage (not reset)
  // ---------------------------------------------------------------------------
  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (push && !Rst) begin
      mem[wr_ptr] <= s1_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Show-ahead output. Dout is forced to zero while the FIFO is empty, so the
  // uninitialised memory never appears at the output after reset.
  // ---------------------------------------------------------------------------
  assign DoutValid = (Count != '0);
  assign Dout      = DoutValid ? mem[rd_ptr] : 8'h00;

endmodule

// File: doc/fir_result_fifo.md
FIR_RESULT_FIFO -- requirements
Module: fir_result_fifo

Interface
REQ-001 The block SHALL provide parameter DEPTH, default 8, FIFO entries; power of two, 2..64.
REQ-002 The block SHALL provide parameter SHIFT, default 8, right-shift applied to filter output; range 1..8.
REQ-003 The block SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-004 The block SHALL have port Rst, input, 1, reset; synchronous, active-high.
REQ-005 The block SHALL have port Yn, input, 16, signed filter output sample.
REQ-006 The block SHALL have port YnValid, input, 1, Yn qualifier; one sample accepted per cycle when high.
REQ-007 The block SHALL have port Dout, output, 8, signed scaled sample at FIFO head.
REQ-008 The block SHALL have port DoutValid, output, 1, FIFO non-empty.
REQ-009 The block SHALL have port DoutReady, input, 1, consumer accept.
REQ-010 The block SHALL have port Count, output, clog2(DEPTH)+1, current FIFO occupancy.
REQ-011 The block SHALL have port Overflow, output, 1, sticky sample-dropped flag.

Function
REQ-012 Stage 1 SHALL register round(Yn / 2^SHIFT) when YnValid=1: a 17-bit sign-extended Yn is increased by 2^(SHIFT-1), then arithmetic-shifted right by SHIFT, i.e. round half toward +inf.
REQ-013 The stage-1 valid bit SHALL follow YnValid with one cycle delay.
REQ-014 The 8-bit result SHALL be the shifted value reduced per REQ-027/REQ-028.
REQ-015 A valid stage-1 entry SHALL be written to FIFO tail on the next edge, unless the FIFO is full and no pop occurs that cycle.
REQ-016 Latency: Yn sampled at edge N SHALL appear at Dout with DoutValid=1 after edge N+1 if the FIFO was empty; no bypass path.
REQ-017 Dout SHALL be show-ahead, driven from the head entry, and valid whenever DoutValid=1.
REQ-018 Pop SHALL occur on an edge where DoutValid=1 and DoutReady=1; DoutReady with DoutValid=0 SHALL have no effect.
REQ-019 A simultaneous push and pop SHALL leave Count unchanged, including when the FIFO is full or holds one entry.
REQ-020 A push attempted when full without a pop SHALL drop the sample and set Overflow=1; Overflow SHALL hold until Rst.
REQ-021 Read and write pointers SHALL wrap modulo DEPTH; Count SHALL range 0..DEPTH.
REQ-022 Consecutive YnValid cycles SHALL sustain one sample per clock while the consumer holds DoutReady=1.

Reset
REQ-023 On an edge with Rst=1, the block SHALL clear pointers, Count=0, DoutValid=0, Overflow=0, and the stage-1 valid bit.
REQ-024 Dout SHALL be 8'h00 during and after reset until the first write.
REQ-025 Rst asserted mid-stream SHALL discard all queued and in-flight samples; a YnValid in the reset cycle SHALL be ignored.
REQ-026 Memory contents SHALL NOT require reset.

Configuration
REQ-027 With macro FIR_RESULT_SAT_EN defined, a shifted value >127 SHALL yield 127 and <-128 SHALL yield -128.
REQ-028 Without FIR_RESULT_SAT_EN, the block SHALL keep the low 8 bits of the shifted value (two's-complement wrap) and include no saturation logic.

Verification
REQ-029 SHIFT=8, Yn=16'h0080 then 16'hFF7F then 16'hFF80, DoutReady=1 -> Dout 8'h01, 8'hFF, 8'h00 on consecutive cycles, first one cycle after the second sampling edge.
REQ-030 Yn=16'h7FFF -> Dout 8'h7F with FIR_RESULT_SAT_EN; 8'h80 without. Yn=16'h8000 -> 8'h80 in both builds.
REQ-031 DEPTH=8, DoutReady=0, 10 consecutive valid samples 1..10 (pre-scale) -> Count=8, Overflow=1; drain yields the first 8 in order, then DoutValid=0, Count=0.
REQ-032 Full FIFO with YnValid=1 and DoutReady=1 held for 20 cycles -> Count stays 8, Overflow stays 0, output order preserved across pointer wrap.
REQ-033 Rst pulsed for 1 cycle with 5 entries queued and YnValid=1 -> next cycle Count=0, DoutValid=0, Overflow=0; following samples are output with normal REQ-016 latency.
